cbd_byte_buffer: RTL and testbench

Collects the SHAKE256 PRF squeeze stream for one noise polynomial. It assembles WORD_W-bit words into a BYTE_COUNT-byte array, which is 128 bytes for eta = 2. It then presents the array, together with its length, to the CBD sampler's byte_array/len inputs and holds it there until the consumer acknowledges it. It sits directly upstream of CBD and gives the sampler a stable, complete input for each polynomial.

---
 rtl/cbd_byte_buffer.sv | 113 +++++++++++
 tb/tb_cbd_byte_buffer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbd_byte_buffer.sv
// cbd_byte_buffer: collects the SHAKE256 PRF squeeze stream for one noise
// polynomial into a BYTE_COUNT-byte array and holds it for the CBD sampler
// until the consumer acknowledges it.
// Optional feature: define CBD_BUF_CHECK_EN to enable the sticky protocol
// error flag (err); otherwise err is tied low and the check logic is absent.
module cbd_byte_buffer #(
  parameter int unsigned WORD_W     = 64,
  parameter int unsigned BYTE_COUNT = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [WORD_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [7:0]                    out_bytes [BYTE_COUNT-1:0],
  output logic [$clog2(BYTE_COUNT):0]   out_len,
  output logic                          out_valid,
  input  logic                          out_ack,
  output logic                          busy,
  output logic                          err
);

  localparam int unsigned NWORDS = BYTE_COUNT * 8 / WORD_W;
  localparam int unsigned WB     = WORD_W / 8;
  localparam int unsigned CW     = $clog2(NWORDS) + 1;
  localparam int unsigned LW     = $clog2(BYTE_COUNT) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);
  localparam logic [LW-1:0] LEN      = LW'(BYTE_COUNT);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;

  // A word is taken only in FILL and only when no restart is requested
  // in the same cycle (a concurrent start discards the word).
  always_comb begin
    accept = (state == FILL) && in_valid && !start;
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state == FILL);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
    out_len   = LEN;
  end

  // Control FSM and word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            cnt   <= '0;
          end
        end
        FILL: begin
          if (start) begin
            cnt <= '0;
          end else if (in_valid) begin
            if (cnt == LAST_CNT) state <= HOLD;
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Byte array write: each byte compares its own word slot against cnt,
  // so every index is a constant and no variable part-select is needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned b = 0; b < BYTE_COUNT; b++) out_bytes[b] <= '0;
    end else if (accept) begin
      for (int unsigned b = 0; b < BYTE_COUNT; b++) begin
        if (cnt == CW'(b / WB)) out_bytes[b] <= in_data[(b % WB) * 8 +: 8];
      end
    end
  end

`ifdef CBD_BUF_CHECK_EN
  logic err_q;

  // Sticky flag: a PRF word offered while not filling, or an ack with no
  // array on offer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if ((in_valid && (state != FILL)) || (out_ack && (state != HOLD))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cbd_byte_buffer.sv
// tb_cbd_byte_buffer: self-checking bench for cbd_byte_buffer. The reference
// model is the list of words accepted since the last start; expected bytes
// and handshake levels are derived from that list.
module tb_cbd_byte_buffer;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned BYTE_COUNT = 128;
  localparam int unsigned NW         = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic [7:0]  out_bytes [BYTE_COUNT-1:0];
  logic [7:0]  out_len;
  logic        out_valid;
  logic        out_ack;
  logic        busy;
  logic        err;

  cbd_byte_buffer #(.WORD_W(WORD_W), .BYTE_COUNT(BYTE_COUNT)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_bytes(out_bytes),
    .out_len(out_len), .out_valid(out_valid), .out_ack(out_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [63:0] acc_q [$];
  logic [7:0]  exp_b [BYTE_COUNT];

`ifdef CBD_BUF_CHECK_EN
  localparam logic EXP_ERR_HOLD = 1'b1;
`else
  localparam logic EXP_ERR_HOLD = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start    = 1'b0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    in_data  = '0;
  endtask

  // Little-endian unpacking of the accepted word list into the byte image.
  function automatic void build_expect();
    for (int b = 0; b < int'(BYTE_COUNT); b++) begin
      logic [63:0] w;
      w = (b / 8 < acc_q.size()) ? acc_q[b / 8] : 64'h0;
      exp_b[b] = 8'(w >> (8 * (b % 8)));
    end
  endfunction

  task automatic test_reset();
    int bad;
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err); end
    tests++; if (out_len !== 8'd128) begin fails++; $display("FAIL reset_out_len got=%0d want=128", out_len); end
    bad = 0;
    for (int b = 0; b < int'(BYTE_COUNT); b++) if (out_bytes[b] !== 8'h00) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_bytes nonzero_count got=%0d want=0", bad); end
    #2 reset = 1'b1;
    step();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_release_in_ready got=%b want=0", in_ready); end
  endtask

  task automatic test_back_to_back();
    int edges, vlat, bad;
    logic [7:0] kb;
    acc_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    edges = 1; vlat = 0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready_after_start got=%b want=1", in_ready); end
    for (int k = 0; k < int'(NW); k++) begin
      kb = 8'(k);
      in_valid = 1'b1;
      in_data  = {8{kb}};
      acc_q.push_back(in_data);
      step();
      edges++;
      if (out_valid === 1'b1 && vlat == 0) vlat = edges;
    end
    in_valid = 1'b0;
    tests++; if (vlat != 17) begin fails++; $display("FAIL b2b_latency got=%0d want=17", vlat); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_in_ready_hold got=%b want=0", in_ready); end
    tests++; if (out_len !== 8'd128) begin fails++; $display("FAIL b2b_out_len got=%0d want=128", out_len); end
    build_expect();
    bad = -1;
    for (int b = BYTE_COUNT - 1; b >= 0; b--) if (out_bytes[b] !== exp_b[b]) bad = b;
    tests++; if (bad >= 0) begin fails++; $display("FAIL b2b_bytes idx=%0d got=%h want=%h", bad, out_bytes[bad], exp_b[bad]); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_ack_out_valid got=%b want=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_ack_busy got=%b want=0", busy); end
  endtask

  task automatic test_gapped();
    int bad;
    int guard;
    acc_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (acc_q.size() < NW && guard < 100) begin
      in_valid = guard[0];
      in_data  = {$urandom, $urandom};
      if (in_valid) acc_q.push_back(in_data);
      step();
      guard++;
      tests++;
      if (out_valid !== (acc_q.size() == NW)) begin
        fails++; $display("FAIL gap_out_valid words=%0d got=%b want=%b", acc_q.size(), out_valid, acc_q.size() == NW);
      end
    end
    in_valid = 1'b0;
    tests++; if (acc_q.size() != NW) begin fails++; $display("FAIL gap_timeout words=%0d want=%0d", acc_q.size(), NW); end
    build_expect();
    bad = -1;
    for (int b = BYTE_COUNT - 1; b >= 0; b--) if (out_bytes[b] !== exp_b[b]) bad = b;
    tests++; if (bad >= 0) begin fails++; $display("FAIL gap_bytes idx=%0d got=%h want=%h", bad, out_bytes[bad], exp_b[bad]); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  task automatic test_hold();
    int bad;
    acc_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(NW); k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      acc_q.push_back(in_data);
      step();
    end
    build_expect();
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", c, in_ready); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_out_valid cyc=%0d got=%b want=1", c, out_valid); end
    end
    in_valid = 1'b0;
    bad = -1;
    for (int b = BYTE_COUNT - 1; b >= 0; b--) if (out_bytes[b] !== exp_b[b]) bad = b;
    tests++; if (bad >= 0) begin fails++; $display("FAIL hold_bytes idx=%0d got=%h want=%h", bad, out_bytes[bad], exp_b[bad]); end
    tests++; if (err !== EXP_ERR_HOLD) begin fails++; $display("FAIL hold_err got=%b want=%b", err, EXP_ERR_HOLD); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  task automatic test_restart();
    int bad, cnt_words;
    acc_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    // restart with a concurrent word that must be discarded
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h0123_4567_89AB_CDEF;
    step();
    start = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL restart_in_ready got=%b want=1", in_ready); end
    cnt_words = 0;
    for (int k = 0; k < int'(NW); k++) begin
      in_valid = 1'b1;
      in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      acc_q.push_back(in_data);
      step();
      cnt_words++;
      tests++;
      if (out_valid !== (cnt_words == int'(NW))) begin
        fails++; $display("FAIL restart_out_valid words=%0d got=%b want=%b", cnt_words, out_valid, cnt_words == int'(NW));
      end
    end
    in_valid = 1'b0;
    build_expect();
    bad = -1;
    for (int b = BYTE_COUNT - 1; b >= 0; b--) if (out_bytes[b] !== exp_b[b]) bad = b;
    tests++; if (bad >= 0) begin fails++; $display("FAIL restart_bytes idx=%0d got=%h want=ff", bad, out_bytes[bad]); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
  endtask

  task automatic test_ack_with_start();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(NW); k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      step();
    end
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_start_ignored got=%b want=1", out_valid); end
    start   = 1'b1;
    out_ack = 1'b1;
    step();
    start   = 1'b0;
    out_ack = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ackstart_out_valid got=%b want=0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ackstart_in_ready got=%b want=0", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ackstart_busy got=%b want=0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ackstart_restart_in_ready got=%b want=1", in_ready); end
    // leave FILL via a fresh start-driven fill so later tests begin clean
    for (int k = 0; k < int'(NW); k++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    out_ack  = 1'b1;
    step();
    out_ack  = 1'b0;
  endtask

  task automatic test_random_fill(input int iter);
    int bad, guard;
    logic s, v;
    acc_q.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (acc_q.size() < NW && guard < 300) begin
      s = (acc_q.size() > 0) && ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) != 0);
      start    = s;
      in_valid = v;
      in_data  = {$urandom, $urandom};
      if (s) acc_q.delete();
      else if (v) acc_q.push_back(in_data);
      step();
      guard++;
      tests++;
      if (in_ready !== (acc_q.size() < NW) || out_valid !== (acc_q.size() == NW)) begin
        fails++; $display("FAIL rand%0d_handshake words=%0d got_rdy=%b got_vld=%b", iter, acc_q.size(), in_ready, out_valid);
      end
    end
    start = 1'b0; in_valid = 1'b0;
    tests++; if (acc_q.size() != NW) begin fails++; $display("FAIL rand%0d_timeout words=%0d want=%0d", iter, acc_q.size(), NW); end
    build_expect();
    bad = -1;
    for (int b = BYTE_COUNT - 1; b >= 0; b--) if (out_bytes[b] !== exp_b[b]) bad = b;
    tests++; if (bad >= 0) begin fails++; $display("FAIL rand%0d_bytes idx=%0d got=%h want=%h", iter, bad, out_bytes[bad], exp_b[bad]); end
    out_ack = 1'b1;
    step();
    out_ack = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rand%0d_ack got=%b want=0", iter, out_valid); end
  endtask

  task automatic test_async_reset();
    int bad;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom} | 64'h1;
      step();
    end
    in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL areset_in_ready got=%b want=0", in_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy got=%b want=0", busy); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid got=%b want=0", out_valid); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL areset_err got=%b want=0", err); end
    tests++; if (out_len !== 8'd128) begin fails++; $display("FAIL areset_out_len got=%0d want=128", out_len); end
    bad = 0;
    for (int b = 0; b < int'(BYTE_COUNT); b++) if (out_bytes[b] !== 8'h00) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL areset_bytes nonzero_count got=%0d want=0", bad); end
    #2 reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL areset_idle_in_ready cyc=%0d got=%b want=0", c, in_ready); end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_start_in_ready got=%b want=1", in_ready); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_hold();
    test_restart();
    test_ack_with_start();
    for (int i = 0; i < 3; i++) test_random_fill(i);
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
